// File: rtl/text_loader.sv
// -----------------------------------------------------------------------------
// text_loader
//   Feeds the single-cycle ARM text processor. Bytes arrive over a valid/ready
//   handshake and are packed little-endian into 32-bit words, which are
//   written through the processor's data-memory write port. When a frame ends
//   the byte length goes to BASE_ADDR, the write port is handed back and start
//   is raised.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   byte on in_data is valid
//   in_data    text byte
//   in_last    final byte of the frame (qualified by in_valid)
//   in_ready   loader accepts a byte this cycle
//   mem_sel    1 = loader owns the dmem write port
//   mem_we     word write strobe
//   mem_addr   word-aligned byte address
//   mem_wdata  word to write
//   start      level, 1 = text loaded and processor may run
//   byte_count bytes stored in the current/last frame (saturating)
//   overflow   sticky per frame, bytes were discarded
// -----------------------------------------------------------------------------
module text_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'd0,
    parameter int          DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_sel,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        start,
    output logic [7:0]  byte_count,
    output logic        overflow
);

    // Text capacity in bytes; the first word of the region holds the length.
    localparam logic [7:0] CAPACITY = 8'((DEPTH_WORDS - 1) * 4);

    typedef enum logic [2:0] {IDLE, FILL, FLUSH, LEN, RUN} state_t;

    state_t      state, state_next;
    logic        armed;
    logic        xfer;
    logic        new_frame;
    logic        store;
    logic        capture;
    logic [1:0]  lane, lane_eff;
    logic [7:0]  word_idx, word_eff;
    logic [7:0]  count_eff;
    logic [31:0] pack_buf, buf_eff, word_new;

    // armed holds in_ready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mem_sel    = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = armed;
                if (armed && in_valid) state_next = in_last ? FLUSH : FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                mem_sel  = 1'b1;
                if (in_valid && in_last) state_next = FLUSH;
            end
            FLUSH: begin
                mem_sel    = 1'b1;
                state_next = LEN;
            end
            LEN: begin
                mem_sel    = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                start    = 1'b1;
                if (in_valid) state_next = in_last ? FLUSH : FILL;
            end
            default: state_next = IDLE;
        endcase
    end

    // A transfer in IDLE or RUN opens a new frame, so all per-frame
    // accounting is taken from zero rather than from the held registers.
    assign xfer      = in_valid && in_ready;
    assign new_frame = (state == IDLE) || (state == RUN);
    assign count_eff = new_frame ? 8'd0  : byte_count;
    assign lane_eff  = new_frame ? 2'd0  : lane;
    assign word_eff  = new_frame ? 8'd0  : word_idx;
    assign buf_eff   = new_frame ? 32'd0 : pack_buf;
    assign store     = xfer && (count_eff < CAPACITY);
    assign word_new  = buf_eff | ({24'd0, in_data} << {lane_eff, 3'b000});
    assign capture   = store && ((lane_eff == 2'd3) || in_last);

    // Writes are registered: a word captured on a transfer appears on the
    // port the following cycle, and addr/wdata hold between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            byte_count <= 8'd0;
            overflow   <= 1'b0;
            pack_buf   <= 32'd0;
            lane       <= 2'd0;
            word_idx   <= 8'd0;
        end else begin
            mem_we <= 1'b0;
            if (xfer) begin
                if (new_frame) overflow <= 1'b0;
                if (store) begin
                    byte_count <= count_eff + 8'd1;
                    if (capture) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE_ADDR + {22'd0, word_eff, 2'b00} + 32'd4;
                        mem_wdata <= word_new;
                        pack_buf  <= 32'd0;
                        lane      <= 2'd0;
                        word_idx  <= word_eff + 8'd1;
                    end else begin
                        pack_buf  <= word_new;
                        lane      <= lane_eff + 2'd1;
                        word_idx  <= word_eff;
                    end
                end else begin
                    byte_count <= count_eff;
                    overflow   <= 1'b1;
                end
            end
            // Any partial word was captured with in_last, so its write lands
            // in the FLUSH cycle; the length write is scheduled here for LEN.
            if (state == FLUSH) begin
                mem_we    <= 1'b1;
                mem_addr  <= BASE_ADDR;
                mem_wdata <= {24'd0, byte_count};
            end
        end
    end

endmodule

// File: tb/tb_text_loader.sv
module tb_text_loader;
    localparam int CAP = 252;

    typedef logic [7:0] bytes_t[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        in_ready, mem_sel, mem_we, start, overflow;
    logic [31:0] mem_addr, mem_wdata;
    logic [7:0]  byte_count;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  stalls  = 0;
    wr_t log_q[$];
    wr_t exp_q[$];

    text_loader #(.BASE_ADDR(32'd0), .DEPTH_WORDS(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .mem_sel(mem_sel),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .start(start), .byte_count(byte_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Record every memory write; a strobe without port ownership is an error.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            log_q.push_back('{mem_addr, mem_wdata});
            n_tests++;
            if (mem_sel !== 1'b1) begin
                n_fail++;
                $display("FAIL we_without_sel: mem_sel=%b required 1 (addr %h)", mem_sel, mem_addr);
            end
        end
    end

    // Reference: what a frame should leave in memory, in write order.
    task automatic model_frame(input bytes_t fr);
        int   stored;
        logic [31:0] w;
        stored = (fr.size() > CAP) ? CAP : fr.size();
        for (int i = 0; i < (stored + 3) / 4; i++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++)
                if (4 * i + j < stored) w = w | (32'(fr[4 * i + j]) << (8 * j));
            exp_q.push_back('{32'(4 * (i + 1)), w});
        end
        exp_q.push_back('{32'd0, 32'(stored)});
    endtask

    function automatic int first_diff();
        int n;
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (log_q[i] !== exp_q[i]) return i;
        if (log_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic push_byte(input logic [7:0] b, input logic last, input bit throttle);
        int g;
        if (throttle) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        g = 0;
        while (in_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        stalls += g;
        if (g >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1 within 50 cycles", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input bytes_t fr, input bit throttle);
        for (int i = 0; i < fr.size(); i++)
            push_byte(fr[i], (i == fr.size() - 1), throttle);
    endtask

    // start level at the negedges of cycles t+1, t+2, t+3 after the last byte.
    task automatic collect_start(output logic [2:0] seq);
        seq[2] = start;
        @(negedge clk); seq[1] = start;
        @(negedge clk); seq[0] = start;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({in_ready, mem_sel, mem_we, mem_addr, mem_wdata, start, byte_count, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b sel=%b we=%b addr=%h wd=%h start=%b cnt=%0d ovf=%b required all 0",
                     in_ready, mem_sel, mem_we, mem_addr, mem_wdata, start, byte_count, overflow);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_clk: in_ready=%b required 0", in_ready);
        end
        @(negedge clk);
        n_tests++;
        if ({in_ready, mem_sel, start} !== 3'b100) begin
            n_fail++;
            $display("FAIL ready_after_release: rdy/sel/start=%b required 100", {in_ready, mem_sel, start});
        end
    endtask

    task automatic test_hello();
        bytes_t fr;
        logic [2:0] seq;
        int d;
        fr = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        log_q.delete(); exp_q.delete(); stalls = 0;
        send_frame(fr, 1'b0);
        collect_start(seq);
        n_tests++;
        if (seq !== 3'b001) begin
            n_fail++;
            $display("FAIL hello_start_latency: start t+1..t+3=%b required 001", seq);
        end
        n_tests++;
        if (log_q.size() != 3 || log_q[0] !== {32'd4, 32'h4C4C4548} ||
            log_q[1] !== {32'd8, 32'h0000004F} || log_q[2] !== {32'd0, 32'd5}) begin
            n_fail++;
            $display("FAIL hello_writes: %0d writes, first %h required 3 writes 4:4C4C4548 8:0000004F 0:5",
                     log_q.size(), (log_q.size() > 0) ? log_q[0] : 64'd0);
        end
        model_frame(fr);
        d = first_diff();
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL hello_model: write %0d differs from reference", d);
        end
        n_tests++;
        if ({byte_count, overflow, stalls != 0} !== {8'd5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hello_status: cnt=%0d ovf=%b stalls=%0d required 5 0 0", byte_count, overflow, stalls);
        end
    endtask

    task automatic test_eight();
        bytes_t fr;
        logic [2:0] seq;
        int d;
        fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        log_q.delete(); exp_q.delete();
        send_frame(fr, 1'b0);
        collect_start(seq);
        model_frame(fr);
        d = first_diff();
        n_tests++;
        if (d != -1 || log_q.size() != 3 || log_q[1] !== {32'd8, 32'h08070605}) begin
            n_fail++;
            $display("FAIL eight_writes: %0d writes, diff at %0d, required 3 writes ending 8:08070605 0:8",
                     log_q.size(), d);
        end
        n_tests++;
        if ({seq, byte_count} !== {3'b001, 8'd8}) begin
            n_fail++;
            $display("FAIL eight_status: start seq=%b cnt=%0d required 001 8", seq, byte_count);
        end
    endtask

    task automatic test_overflow();
        bytes_t fr;
        logic [2:0] seq;
        logic [31:0] max_addr;
        int d;
        for (int i = 0; i < 260; i++) fr.push_back(8'($urandom));
        log_q.delete(); exp_q.delete(); stalls = 0;
        send_frame(fr, 1'b1);
        collect_start(seq);
        model_frame(fr);
        d = first_diff();
        n_tests++;
        if (d != -1 || log_q.size() != 64) begin
            n_fail++;
            $display("FAIL overflow_writes: %0d writes, diff at %0d, required 64 matching reference", log_q.size(), d);
        end
        max_addr = 32'd0;
        foreach (log_q[i]) if (log_q[i].addr > max_addr) max_addr = log_q[i].addr;
        n_tests++;
        if (max_addr !== 32'd252) begin
            n_fail++;
            $display("FAIL overflow_max_addr: highest write %0d required 252", max_addr);
        end
        n_tests++;
        if ({byte_count, overflow, seq} !== {8'd252, 1'b1, 3'b001}) begin
            n_fail++;
            $display("FAIL overflow_status: cnt=%0d ovf=%b start seq=%b required 252 1 001", byte_count, overflow, seq);
        end
        n_tests++;
        if (stalls != 0) begin
            n_fail++;
            $display("FAIL overflow_ready: %0d stall cycles required 0", stalls);
        end
    endtask

    task automatic test_new_frame();
        bytes_t fr;
        logic [2:0] seq;
        int d;
        fr = '{8'h41};
        n_tests++;
        if (start !== 1'b1) begin
            n_fail++;
            $display("FAIL run_start: start=%b required 1", start);
        end
        log_q.delete(); exp_q.delete();
        send_frame(fr, 1'b0);
        collect_start(seq);
        model_frame(fr);
        d = first_diff();
        n_tests++;
        if (d != -1 || log_q.size() != 2 || log_q[0] !== {32'd4, 32'h41}) begin
            n_fail++;
            $display("FAIL newframe_writes: %0d writes, diff at %0d, required 4:00000041 0:1", log_q.size(), d);
        end
        n_tests++;
        if ({seq, byte_count, overflow} !== {3'b001, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL newframe_status: start seq=%b cnt=%0d ovf=%b required 001 1 0", seq, byte_count, overflow);
        end
    endtask

    task automatic test_hold_flush();
        bytes_t fr1, fr2;
        logic [2:0] seq;
        int d;
        fr1 = '{8'($urandom), 8'($urandom), 8'($urandom)};
        fr2 = '{8'h5A};
        log_q.delete(); exp_q.delete();
        send_frame(fr1, 1'b0);
        stalls = 0;
        push_byte(8'h5A, 1'b1, 1'b0);
        n_tests++;
        if (stalls != 2) begin
            n_fail++;
            $display("FAIL hold_flush_stalls: waited %0d cycles required 2", stalls);
        end
        collect_start(seq);
        model_frame(fr1);
        model_frame(fr2);
        d = first_diff();
        n_tests++;
        if (d != -1 || seq !== 3'b001) begin
            n_fail++;
            $display("FAIL hold_flush_writes: diff at %0d (%0d writes) start seq=%b required none 001",
                     d, log_q.size(), seq);
        end
    endtask

    task automatic test_random();
        bytes_t fr;
        logic [2:0] seq;
        int d, n;
        for (int f = 0; f < 6; f++) begin
            fr.delete();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
            log_q.delete(); exp_q.delete();
            send_frame(fr, 1'b1);
            collect_start(seq);
            model_frame(fr);
            d = first_diff();
            n_tests++;
            if (d != -1 || {seq, byte_count, overflow} !== {3'b001, 8'(n), 1'b0}) begin
                n_fail++;
                $display("FAIL random_frame%0d: len=%0d diff at %0d seq=%b cnt=%0d ovf=%b required none 001 %0d 0",
                         f, n, d, seq, byte_count, overflow, n);
            end
        end
    endtask

    task automatic test_reset_mid();
        log_q.delete();
        push_byte(8'h11, 1'b0, 1'b0);
        push_byte(8'h22, 1'b0, 1'b0);
        push_byte(8'h33, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, mem_sel, mem_we, mem_addr, mem_wdata, start, byte_count, overflow} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: rdy=%b sel=%b we=%b cnt=%0d start=%b required all 0",
                     in_ready, mem_sel, mem_we, byte_count, start);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({in_ready, mem_sel, start, log_q.size() == 0} !== 4'b1001) begin
            n_fail++;
            $display("FAIL midreset_release: rdy/sel/start=%b writes=%0d required 100 0",
                     {in_ready, mem_sel, start}, log_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_hello();
        test_eight();
        test_overflow();
        test_new_frame();
        test_hold_flush();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
